ps2_frame_rx: RTL and testbench

Receives PS/2 device-to-host frames from a keyboard, checks their framing and parity, and buffers the scan codes in a small first-word-fall-through FIFO. It is the input stage of the keyboard path. The scan-code state machine downstream pops bytes with the `ready` / `nextdata_n` handshake. The block also flags overflow and framing errors so the consumer can detect lost keystrokes.

---
 rtl/ps2_frame_rx_if.sv | 27 ++
 rtl/ps2_frame_rx.sv | 158 +++++++++++++++
 tb/tb_ps2_frame_rx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_frame_rx_if.sv
// Consumer-side handshake of the PS/2 receiver: FIFO head byte, status flags
// and the active-low pop request.
interface ps2_frame_rx_if;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   // Receiver side: presents the FIFO head and status, accepts pops.
   modport slave (
      input  nextdata_n,
      output data,
      output ready,
      output overflow,
      output frame_err
   );

   // Consumer side: pops bytes and watches the status flags.
   modport master (
      output nextdata_n,
      input  data,
      input  ready,
      input  overflow,
      input  frame_err
   );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
// It synchronizes the PS/2 lines and shifts in 11-bit frames on falling
// ps2_clk edges. It checks start, stop and odd parity, and queues good bytes
// in a first-word-fall-through FIFO that the consumer pops with nextdata_n.
module ps2_frame_rx #(
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ps2_clk,
   input  logic           ps2_data,
   ps2_frame_rx_if.slave  fifo_if
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic {IDLE, RECV} state_t;

   // index 0 = s0 (pin side), 1 = s1, 2 = s2
   logic [2:0]    ps2_clk_sync_reg;
   // The data bit is taken at s1, so the data chain ends at s1.
   // A third stage on this line would never be read.
   logic [1:0]    ps2_data_sync_reg;
   logic          fall;
   logic          bit_in;

   state_t        state_reg, state_next;
   logic [3:0]    bit_cnt_reg;
   // Holds the bits received before the current edge.
   // Together with bit_in it forms the full 11-bit frame on the stop edge.
   logic [9:0]    shift_reg;
   logic [TW-1:0] idle_cnt_reg;
   logic          frame_last;
   logic          timeout_hit;
   logic [10:0]   frame_word;
   logic          frame_ok;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
   logic [AW:0]   count_reg, count_next;
   logic [7:0]    data_reg, data_next;
   logic          overflow_reg, frame_err_reg;
   logic          push_req, push, pop, drop;

   // Sync both PS/2 lines into clk; flops idle high like the bus.
   always_ff @(posedge clk) begin
      if (reset) begin
         ps2_clk_sync_reg  <= 3'b111;
         ps2_data_sync_reg <= 2'b11;
      end else begin
         ps2_clk_sync_reg  <= {ps2_clk_sync_reg[1:0], ps2_clk};
         ps2_data_sync_reg <= {ps2_data_sync_reg[0], ps2_data};
      end
   end

   assign fall   = ps2_clk_sync_reg[2] & ~ps2_clk_sync_reg[1];
   assign bit_in = ps2_data_sync_reg[1];

   // Frame as it stands after the current edge: [0]=start, [8:1]=byte, [9]=parity, [10]=stop.
   assign frame_word = {bit_in, shift_reg};
   assign frame_ok   = ~frame_word[0] & frame_word[10] & (^frame_word[9:1]);

   // Receiver state register.
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Receiver next state: start on the first edge, finish on the 11th edge or on timeout.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (fall) state_next = RECV;
         RECV: if (frame_last || timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Receiver outputs: stop-bit edge and mid-frame timeout.
   always_comb begin
      frame_last  = 1'b0;
      timeout_hit = 1'b0;
      if (state_reg == RECV) begin
         frame_last  = fall && (bit_cnt_reg == 4'd10);
         timeout_hit = !fall && (idle_cnt_reg == TW'(TIMEOUT_CYC));
      end
   end

   // Bit counter, shift register and idle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt_reg  <= 4'd0;
         shift_reg    <= 10'd0;
         idle_cnt_reg <= '0;
      end else if (fall) begin
         shift_reg    <= frame_word[10:1];
         bit_cnt_reg  <= frame_last ? 4'd0 : bit_cnt_reg + 4'd1;
         idle_cnt_reg <= '0;
      end else if (timeout_hit) begin
         bit_cnt_reg  <= 4'd0;
         shift_reg    <= 10'd0;
         idle_cnt_reg <= '0;
      end else if (state_reg == RECV) begin
         idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end else begin
         idle_cnt_reg <= '0;
      end
   end

   // A pop may free the slot for a same-cycle push, so a full FIFO still accepts a frame.
   assign pop      = ~fifo_if.nextdata_n && (count_reg != '0);
   assign push_req = frame_last && frame_ok;
   assign push     = push_req && ((count_reg != (AW+1)'(DEPTH)) || pop);
   assign drop     = push_req && !push;

   // FIFO pointer/count update and the registered head byte (bypass when the head is being written).
   always_comb begin
      wr_ptr_next = wr_ptr_reg + AW'(push);
      rd_ptr_next = rd_ptr_reg + AW'(pop);
      count_next  = count_reg + (AW+1)'(push) - (AW+1)'(pop);
      data_next   = 8'h00;
      if (count_next != '0) begin
         if (push && (rd_ptr_next == wr_ptr_reg)) data_next = frame_word[8:1];
         else                                     data_next = mem[rd_ptr_next];
      end
   end

   // FIFO storage; contents are left untouched by reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= frame_word[8:1];
   end

   // FIFO state and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         data_reg      <= 8'h00;
         overflow_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         data_reg      <= data_next;
         frame_err_reg <= frame_last && !frame_ok;
         if (drop)     overflow_reg <= 1'b1;
         else if (pop) overflow_reg <= 1'b0;
      end
   end

   assign fifo_if.data      = data_reg;
   assign fifo_if.ready     = (count_reg != '0);
   assign fifo_if.overflow  = overflow_reg;
   assign fifo_if.frame_err = frame_err_reg;
endmodule

// File: tb/tb_ps2_frame_rx.sv
// Testbench for ps2_frame_rx.
// It drives directed scenarios plus randomized frames and pops, and checks
// the outputs against a queue-based model of the byte stream.
module tb_ps2_frame_rx;
   localparam int HALF = 20;   // clk cycles per PS/2 half period
   localparam int GAP  = 300;  // idle gap longer than the timeout

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;
   ps2_frame_rx_if bus();

   ps2_frame_rx #(.DEPTH(8), .TIMEOUT_CYC(200)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .fifo_if(bus)
   );

   always #5 clk = ~clk;

   logic [7:0] q[$];
   bit         m_ovf = 1'b0;
   int         m_err = 0;
   int         n_cmp = 0, n_mis = 0;
   int         err_cnt = 0, err_wide = 0, err_base = 0;
   logic       err_prev = 1'b0;

   always @(posedge clk) begin
      err_prev <= bus.frame_err;
      if (bus.frame_err) err_cnt <= err_cnt + 1;
      if (bus.frame_err && err_prev) err_wide <= err_wide + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b, input int kind);
      logic par, stop, start;
      par   = (~^b) ^ (kind == 1);
      stop  = (kind != 2);
      start = (kind == 3);
      return {stop, par, b, start};
   endfunction

   task automatic check_state(input string tag);
      @(negedge clk);
      check_val({tag, "_ready"}, bus.ready, q.size() != 0);
      check_val({tag, "_data"}, bus.data, (q.size() != 0) ? q[0] : 8'h00);
      check_val({tag, "_ovf"}, bus.overflow, m_ovf);
      check_val({tag, "_errs"}, err_cnt - err_base, m_err);
      check_val({tag, "_errw"}, err_wide, 0);
      $display("check %s: ready=%0d data=%02h ovf=%0d model_depth=%0d", tag, bus.ready, bus.data, bus.overflow, q.size());
   endtask

   task automatic send_bits(input logic [10:0] fr, input int first, input int last, input bit tchk);
      for (int i = first; i <= last; i++) begin
         @(negedge clk) ps2_data = fr[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         if (tchk && i == 10) begin
            repeat (2) @(negedge clk);
            check_val("lat_early", bus.ready, 1'b0);
            @(negedge clk);
            check_val("lat_ready", bus.ready, 1'b1);
            check_val("lat_data", bus.data, fr[8:1]);
            repeat (HALF - 3) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input int kind, input bit tchk);
      send_bits(make_frame(b, kind), 0, 10, tchk);
      if (kind == 0) begin
         if (q.size() < 8) q.push_back(b);
         else m_ovf = 1'b1;
      end else begin
         m_err++;
      end
      repeat (10) @(negedge clk);
      $display("frame %02h kind=%0d sent", b, kind);
   endtask

   task automatic pop_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_val("pop_ready", bus.ready, q.size() != 0);
         check_val("pop_data", bus.data, (q.size() != 0) ? q[0] : 8'h00);
         check_val("pop_ovf", bus.overflow, m_ovf);
         $display("pop %0d: data=%02h ready=%0d", i, bus.data, bus.ready);
         bus.nextdata_n = 1'b0;
         if (q.size() != 0) begin
            void'(q.pop_front());
            m_ovf = 1'b0;
         end
      end
      @(negedge clk);
      bus.nextdata_n = 1'b1;
   endtask

   initial begin
      logic [10:0] fr;
      bus.nextdata_n = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_data", bus.data, 8'h00);
      check_val("rst_ready", bus.ready, 1'b0);
      check_val("rst_ovf", bus.overflow, 1'b0);
      check_val("rst_ferr", bus.frame_err, 1'b0);
      reset = 1'b0;
      check_state("reset");

      // single frame with latency check
      send_frame(8'h1C, 0, 1'b1);
      check_state("single");
      pop_n(1);
      check_state("single_pop");

      // break sequence, consecutive pops
      send_frame(8'h1C, 0, 1'b0);
      send_frame(8'hF0, 0, 1'b0);
      send_frame(8'h1C, 0, 1'b0);
      check_state("break");
      pop_n(3);
      check_state("break_pop");

      // parity error then good frame
      send_frame(8'h32, 1, 1'b0);
      check_state("parity_bad");
      send_frame(8'h32, 0, 1'b0);
      check_state("parity_good");
      pop_n(1);

      // overflow and pointer wrap
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1'b0);
      check_state("ovf_full");
      pop_n(8);
      check_state("ovf_drain");
      pop_n(2);
      check_state("empty_pop");

      // timeout of a partial frame
      send_bits(make_frame(8'hA7, 0), 0, 4, 1'b0);
      repeat (250) @(negedge clk);
      send_frame(8'h1C, 0, 1'b0);
      check_state("timeout");
      pop_n(1);

      // reset in the middle of a frame with bytes queued
      send_frame(8'h11, 0, 1'b0);
      send_frame(8'h22, 0, 1'b0);
      fr = make_frame(8'h5A, 0);
      send_bits(fr, 0, 5, 1'b0);
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      check_state("midrst");
      send_bits(fr, 6, 10, 1'b0);
      repeat (GAP) @(negedge clk);
      err_base = err_cnt;   // the stop edge of the abandoned frame may pulse frame_err
      m_err = 0;
      check_state("midrst_tail");
      send_frame(8'h15, 0, 1'b0);
      check_state("midrst_next");
      pop_n(1);

      // randomized frames, errors, partial frames and pops
      for (int it = 0; it < 15; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if ($urandom_range(0, 5) == 0) begin
            send_bits(make_frame(8'($urandom), 0), 0, $urandom_range(0, 9), 1'b0);
            repeat (GAP) @(negedge clk);
         end
         send_frame(8'($urandom), (r < 3) ? r + 1 : 0, 1'b0);
         pop_n($urandom_range(0, 3));
         check_state($sformatf("rand%0d", it));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
